dm_dmi_regs: RTL and testbench
==============================

Name: dm_dmi_regs

Overview:
- DMI target inside the Debug Module. It sits directly downstream of dmi_jtag and consumes the dm::dmi_req_t requests that dmi_jtag produces.
- Decodes each request and services a small set of DM registers: data0..dataN, dmcontrol, dmstatus, hartinfo, abstractcs.
- Returns one dm::dmi_resp_t per accepted request and drives hart-control levels and pulses toward the hart interface.
- Single outstanding request, buffered response.

Parameters:
- DataCount, 2, number of dataN registers at addr 0x04..0x04+DataCount-1; legal 1..12
- Version, 4'd2, value returned in dmstatus.version[3:0]

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- dmi_clear_i  in  1  from dmi_jtag dmi_clear_o; drops pending response
- dmi_req_i  in  dm::dmi_req_t  {addr[6:0], op[1:0], data[31:0]}
- dmi_req_valid_i  in  1  request valid
- dmi_req_ready_o  out  1  request accepted when valid&ready
- dmi_resp_o  out  dm::dmi_resp_t  {data[31:0], resp[1:0]}
- dmi_resp_valid_o  out  1  response valid
- dmi_resp_ready_i  in  1  response consumed when valid&ready
- hart_halted_i  in  1  hart halted status
- auth_i  in  1  authentication status (used only with DM_AUTHGATE_EN)
- dmactive_o  out  1  dmcontrol.dmactive
- ndmreset_o  out  1  dmcontrol.ndmreset
- haltreq_o  out  1  dmcontrol.haltreq level
- resumereq_o  out  1  one-cycle resume pulse

Behaviour:
- Reset (rst_i=1 at posedge): all outputs 0, all registers 0, cmderr=0, no pending response.
- State machine, two states:
  - IDLE: dmi_req_ready_o=1. On valid&ready, execute the access, latch the response, go to RESP.
  - RESP: dmi_req_ready_o=0, dmi_resp_valid_o=1, dmi_resp_o held stable. On dmi_resp_ready_i, go to IDLE.
- Latency: response valid exactly 1 cycle after acceptance. Next acceptance no earlier than the cycle after the response handshake. No bypass.
- Ops:
  - 0 NOP: resp=0, data=0.
  - 1 READ: resp=0, data=register value.
  - 2 WRITE: resp=0, data=0, register updated at the acceptance edge.
  - 3 reserved: resp=2 (failed), no side effect.
- Register map:
  - data0..: R/W 32b.
  - 0x10 dmcontrol: bit0 dmactive, bit1 ndmreset, bit30 resumereq (W1, reads 0), bit31 haltreq. Other bits read 0.
  - 0x11 dmstatus, RO:
    - [3:0] Version
    - [7] authenticated=1
    - [8] anyhalted = [9] allhalted = hart_halted_i
    - [10] anyrunning = [11] allrunning = !hart_halted_i
    - [22] impebreak=0
  - 0x12 hartinfo: RO 0.
  - 0x16 abstractcs:
    - [3:0] DataCount
    - [10:8] cmderr, W1C per bit
    - [12] busy=0
    - [28:24] progbufsize=0
  - Any other addr: read 0, write ignored, resp=0.
- dmactive=0 holds the DM in reset:
  - data regs, cmderr, ndmreset and haltreq held 0.
  - Writes to dmcontrol update only dmactive; other writes are ignored.
  - Reads are still served normally.
- resumereq_o pulses for 1 cycle after a dmcontrol write with bit30=1, bit31=0, dmactive=1. If haltreq=1 and resumereq=1 are written together, haltreq wins and there is no pulse.
- Data addr 0x04+DataCount or above is treated as unknown.
- dmi_clear_i=1 (takes priority):
  - Discards any pending response: RESP->IDLE, resp_valid=0 next cycle.
  - Forces dmi_req_ready_o=0 during that cycle.
  - Register contents are kept.
- Reset mid-RESP: the response is dropped with no handshake.

Optional Feature:
- Macro DM_AUTHGATE_EN.
- Defined:
  - dmstatus.authenticated = auth_i.
  - While auth_i=0: every access except a dmstatus read returns data=0 and writes have no effect; resp stays 0.
- Undefined: authenticated=1 and auth_i is ignored (port kept, unused).

Decomposition:
- dm package: dmi_req_t, dmi_resp_t, op and resp encodings, register address constants (Data0, DMControl, DMStatus, HartInfo, AbstractCS), bitfield structs for dmcontrol, dmstatus and abstractcs.
- No sub-module: decode and FSM are compact enough to stay flat.

Test Plan:
- Reset, then write dmcontrol 0x00000001, then read 0x10 -> read returns 0x00000001; dmactive_o=1.
- Write data0=0xDEADBEEF and data1=0x12345678, read both -> same values, resp=0; read addr 0x06 -> 0, resp=0.
- dmactive=1, write dmcontrol 0x40000001 -> resumereq_o high exactly 1 cycle. Write 0xC0000001 -> haltreq_o=1, no pulse. Set hart_halted_i=1 -> dmstatus read = 0x00000382.
- Op=3 to any addr -> resp=2, no state change. Hold dmi_resp_ready_i=0 for 5 cycles -> resp stable, req_ready=0, a second request is not accepted.
- Pulse dmi_clear_i while in RESP -> resp_valid drops next cycle; data0 unchanged on the following read.
- Write dmcontrol 0, then write data0=5, read data0 -> 0. Write abstractcs 0x700 -> cmderr stays 0, and the read shows 0x00000002 for DataCount=2.

Source files
------------

// File: rtl/dm_dmi_regs_pkg.sv
// dm_dmi_regs_pkg: shared types for the Debug Module DMI register target.
//   - DMI request/response structs exchanged with dmi_jtag
//   - op / resp encodings, DM register addresses
//   - bitfield views of dmcontrol, dmstatus and abstractcs
package dm_dmi_regs_pkg;

    typedef enum logic [1:0] {
        DTM_NOP   = 2'd0,
        DTM_READ  = 2'd1,
        DTM_WRITE = 2'd2,
        DTM_RSVD  = 2'd3
    } dtm_op_e;

    localparam logic [1:0] DTM_SUCCESS = 2'd0;
    localparam logic [1:0] DTM_ERR     = 2'd2;

    localparam logic [6:0] Data0      = 7'h04;
    localparam logic [6:0] DMControl  = 7'h10;
    localparam logic [6:0] DMStatus   = 7'h11;
    localparam logic [6:0] HartInfo   = 7'h12;
    localparam logic [6:0] AbstractCS = 7'h16;

    typedef struct packed {
        logic [6:0]  addr;
        dtm_op_e     op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;

    typedef struct packed {
        logic        haltreq;
        logic        resumereq;
        logic [27:0] zero0;
        logic        ndmreset;
        logic        dmactive;
    } dmcontrol_t;

    typedef struct packed {
        logic [8:0] zero0;
        logic       impebreak;
        logic [9:0] zero1;
        logic       allrunning;
        logic       anyrunning;
        logic       allhalted;
        logic       anyhalted;
        logic       authenticated;
        logic [2:0] zero2;
        logic [3:0] version;
    } dmstatus_t;

    typedef struct packed {
        logic [2:0]  zero0;
        logic [4:0]  progbufsize;
        logic [10:0] zero1;
        logic        busy;
        logic        zero2;
        logic [2:0]  cmderr;
        logic [3:0]  zero3;
        logic [3:0]  datacount;
    } abstractcs_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } dmi_state_e;

endpackage

// File: rtl/dm_dmi_regs.sv
// dm_dmi_regs: DMI target of the Debug Module. Accepts one dmi_req_t at a
// time, executes it against data0..dataN / dmcontrol / dmstatus / hartinfo /
// abstractcs, and holds the dmi_resp_t until the requester takes it.
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   dmi_clear_i                       drops any pending response
//   dmi_req_i/_valid_i/_ready_o       request channel
//   dmi_resp_o/_valid_o/_ready_i      response channel
//   hart_halted_i                     hart status for dmstatus
//   auth_i                            authentication status
//   dmactive_o, ndmreset_o, haltreq_o dmcontrol levels
//   resumereq_o                       one-cycle resume pulse
//
// Build option: define DM_AUTHGATE_EN to gate all accesses except a dmstatus
// read on auth_i. Without it the DM always reports authenticated and auth_i
// is ignored.
module dm_dmi_regs
    import dm_dmi_regs_pkg::*;
#(
    parameter int unsigned DataCount = 2,
    parameter logic [3:0]  Version   = 4'd2
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      dmi_clear_i,
    input  dmi_req_t  dmi_req_i,
    input  logic      dmi_req_valid_i,
    output logic      dmi_req_ready_o,
    output dmi_resp_t dmi_resp_o,
    output logic      dmi_resp_valid_o,
    input  logic      dmi_resp_ready_i,
    input  logic      hart_halted_i,
    input  logic      auth_i,
    output logic      dmactive_o,
    output logic      ndmreset_o,
    output logic      haltreq_o,
    output logic      resumereq_o
);

    dmi_state_e state_q, state_d;

    logic [DataCount-1:0][31:0] data_q;
    logic       dmactive_q, ndmreset_q, haltreq_q, resumereq_q;
    logic [2:0] cmderr_q;
    dmi_resp_t  resp_q, resp_d;

    logic        accept, gated, wr_en, auth_ok;
    logic [31:0] rdata;
    logic [31:0] wd;
    dmcontrol_t  dmc_rd;
    dmstatus_t   dms_rd;
    abstractcs_t acs_rd;

`ifdef DM_AUTHGATE_EN
    assign auth_ok = auth_i;
`else
    logic unused_auth;
    assign unused_auth = auth_i;
    assign auth_ok     = 1'b1;
`endif

    assign wd     = dmi_req_i.data;
    assign accept = dmi_req_valid_i & dmi_req_ready_o;

    // Unauthenticated: only a dmstatus read gets through, so the debugger
    // can still observe the authenticated bit.
    assign gated = !auth_ok && !(dmi_req_i.op == DTM_READ && dmi_req_i.addr == DMStatus);
    assign wr_en = accept && dmi_req_i.op == DTM_WRITE && !gated;

    // ---------------- state register ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // ---------------- next state ----------------
    always_comb begin
        state_d = state_q;
        if (dmi_clear_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (dmi_req_valid_i)  state_d = S_RESP;
                S_RESP: if (dmi_resp_ready_i) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ---------------- FSM outputs ----------------
    always_comb begin
        dmi_req_ready_o  = (state_q == S_IDLE) && !dmi_clear_i;
        dmi_resp_valid_o = (state_q == S_RESP);
    end

    // ---------------- read decode ----------------
    always_comb begin
        dmc_rd           = '0;
        dmc_rd.dmactive  = dmactive_q;
        dmc_rd.ndmreset  = ndmreset_q;
        dmc_rd.haltreq   = haltreq_q;

        dms_rd               = '0;
        dms_rd.version       = Version;
        dms_rd.authenticated = auth_ok;
        dms_rd.anyhalted     = hart_halted_i;
        dms_rd.allhalted     = hart_halted_i;
        dms_rd.anyrunning    = !hart_halted_i;
        dms_rd.allrunning    = !hart_halted_i;

        acs_rd           = '0;
        acs_rd.datacount = 4'(DataCount);
        acs_rd.cmderr    = cmderr_q;

        rdata = '0;
        case (dmi_req_i.addr)
            DMControl:  rdata = dmc_rd;
            DMStatus:   rdata = dms_rd;
            HartInfo:   rdata = '0;
            AbstractCS: rdata = acs_rd;
            default: begin
                for (int i = 0; i < DataCount; i++)
                    if (dmi_req_i.addr == 7'(Data0 + 7'(i))) rdata = data_q[i];
            end
        endcase
    end

    always_comb begin
        resp_d = '{data: 32'h0, resp: DTM_SUCCESS};
        case (dmi_req_i.op)
            DTM_READ: resp_d.data = gated ? 32'h0 : rdata;
            DTM_RSVD: resp_d.resp = DTM_ERR;
            default:  ;
        endcase
    end

    // ---------------- register file ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q      <= '0;
            dmactive_q  <= 1'b0;
            ndmreset_q  <= 1'b0;
            haltreq_q   <= 1'b0;
            resumereq_q <= 1'b0;
            cmderr_q    <= '0;
            resp_q      <= '0;
        end else begin
            resumereq_q <= 1'b0;
            if (accept) resp_q <= resp_d;

            // dmactive low keeps the rest of the DM in reset.
            if (!dmactive_q) begin
                data_q     <= '0;
                cmderr_q   <= '0;
                ndmreset_q <= 1'b0;
                haltreq_q  <= 1'b0;
            end

            if (wr_en) begin
                if (dmi_req_i.addr == DMControl) begin
                    dmactive_q <= wd[0];
                    if (dmactive_q) begin
                        ndmreset_q  <= wd[0] & wd[1];
                        haltreq_q   <= wd[0] & wd[31];
                        // haltreq wins over a simultaneous resumereq
                        resumereq_q <= wd[0] & wd[30] & ~wd[31];
                    end
                end else if (dmactive_q) begin
                    if (dmi_req_i.addr == AbstractCS)
                        cmderr_q <= cmderr_q & ~wd[10:8];
                    for (int i = 0; i < DataCount; i++)
                        if (dmi_req_i.addr == 7'(Data0 + 7'(i))) data_q[i] <= wd;
                end
            end
        end
    end

    assign dmi_resp_o  = resp_q;
    assign dmactive_o  = dmactive_q;
    assign ndmreset_o  = ndmreset_q;
    assign haltreq_o   = haltreq_q;
    assign resumereq_o = resumereq_q;

endmodule

// File: tb/tb_dm_dmi_regs.sv
// tb_dm_dmi_regs: directed test of dm_dmi_regs. Stimulus pushes the expected
// response for every accepted request; a monitor pops and compares on each
// response handshake.
module tb_dm_dmi_regs;
    import dm_dmi_regs_pkg::*;

    logic      clk = 1'b0;
    logic      rst = 1'b1;
    logic      dmi_clear = 1'b0;
    dmi_req_t  req = '0;
    logic      req_valid = 1'b0;
    logic      req_ready;
    dmi_resp_t resp;
    logic      resp_valid;
    logic      resp_ready = 1'b1;
    logic      hart_halted = 1'b0;
    logic      auth = 1'b1;
    logic      dmactive, ndmreset, haltreq, resumereq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  r;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    dm_dmi_regs #(.DataCount(2), .Version(4'd2)) dut (
        .clk_i(clk), .rst_i(rst), .dmi_clear_i(dmi_clear),
        .dmi_req_i(req), .dmi_req_valid_i(req_valid), .dmi_req_ready_o(req_ready),
        .dmi_resp_o(resp), .dmi_resp_valid_o(resp_valid), .dmi_resp_ready_i(resp_ready),
        .hart_halted_i(hart_halted), .auth_i(auth),
        .dmactive_o(dmactive), .ndmreset_o(ndmreset), .haltreq_o(haltreq),
        .resumereq_o(resumereq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: compare each handshaken response against the scoreboard.
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got data 0x%08h resp %0d with nothing expected",
                         resp.data, resp.resp);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_data", resp.data, e.d);
                chk("resp_code", 32'(resp.resp), 32'(e.r));
            end
        end
    end

    // Issue one request; returns just after the accepting edge.
    task automatic send(input logic [6:0] addr, input logic [1:0] op, input logic [31:0] data,
                        input logic [31:0] exp_d, input logic [1:0] exp_r, input bit push);
        int n = 0;
        @(negedge clk);
        req.addr  = addr;
        req.op    = dtm_op_e'(op);
        req.data  = data;
        req_valid = 1'b1;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: req_ready stayed 0 for %0d cycles, expected 1", n);
        end
        if (push) exp_q.push_back('{d: exp_d, r: exp_r});
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || resp_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
        end
    endtask

    initial begin
        int pulses;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_outputs", {28'h0, dmactive, ndmreset, haltreq, resumereq}, 32'h0);

        // activate, read back dmcontrol
        send(DMControl, 2'd2, 32'h0000_0001, 32'h0, 2'd0, 1'b1);
        send(DMControl, 2'd1, 32'h0, 32'h0000_0001, 2'd0, 1'b1);
        drain();
        chk("dmactive_o", 32'(dmactive), 32'd1);

        // data registers and unknown address
        send(7'h04, 2'd2, 32'hDEAD_BEEF, 32'h0, 2'd0, 1'b1);
        send(7'h05, 2'd2, 32'h1234_5678, 32'h0, 2'd0, 1'b1);
        send(7'h04, 2'd1, 32'h0, 32'hDEAD_BEEF, 2'd0, 1'b1);
        send(7'h05, 2'd1, 32'h0, 32'h1234_5678, 2'd0, 1'b1);
        send(7'h06, 2'd1, 32'h0, 32'h0, 2'd0, 1'b1);
        send(7'h06, 2'd0, 32'hFFFF_FFFF, 32'h0, 2'd0, 1'b1);
        send(HartInfo, 2'd1, 32'h0, 32'h0, 2'd0, 1'b1);
        drain();

        // resume pulse lasts exactly one cycle
        send(DMControl, 2'd2, 32'h4000_0001, 32'h0, 2'd0, 1'b1);
        chk("resume_pulse_hi", 32'(resumereq), 32'd1);
        @(negedge clk);
        chk("resume_pulse_hi_mid", 32'(resumereq), 32'd1);
        @(negedge clk);
        chk("resume_pulse_lo", 32'(resumereq), 32'd0);
        drain();

        // haltreq wins over resumereq
        pulses = 0;
        send(DMControl, 2'd2, 32'hC000_0001, 32'h0, 2'd0, 1'b1);
        repeat (3) begin
            if (resumereq) pulses++;
            @(negedge clk);
        end
        chk("halt_no_pulse", 32'(pulses), 32'd0);
        chk("haltreq_o", 32'(haltreq), 32'd1);
        hart_halted = 1'b1;
        send(DMStatus, 2'd1, 32'h0, 32'h0000_0382, 2'd0, 1'b1);
        send(DMControl, 2'd1, 32'h0, 32'h8000_0001, 2'd0, 1'b1);
        drain();

        // reserved op under backpressure
        resp_ready = 1'b0;
        send(7'h04, 2'd3, 32'h0000_0BAD, 32'h0, 2'd2, 1'b1);
        @(negedge clk);
        req.addr = 7'h05; req.op = DTM_WRITE; req.data = 32'hFFFF_FFFF;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_resp_valid", 32'(resp_valid), 32'd1);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            chk("stall_resp_code", 32'(resp.resp), 32'd2);
            @(negedge clk);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        drain();
        send(7'h04, 2'd1, 32'h0, 32'hDEAD_BEEF, 2'd0, 1'b1);
        send(7'h05, 2'd1, 32'h0, 32'h1234_5678, 2'd0, 1'b1);
        drain();

        // clear drops a pending response
        resp_ready = 1'b0;
        send(7'h04, 2'd1, 32'h0, 32'h0, 2'd0, 1'b0);
        @(negedge clk);
        chk("clear_pre_valid", 32'(resp_valid), 32'd1);
        dmi_clear = 1'b1;
        chk("clear_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        dmi_clear = 1'b0;
        chk("clear_post_valid", 32'(resp_valid), 32'd0);
        resp_ready = 1'b1;
        send(7'h04, 2'd1, 32'h0, 32'hDEAD_BEEF, 2'd0, 1'b1);
        drain();

        // deactivate: DM held in reset
        send(DMControl, 2'd2, 32'h0000_0000, 32'h0, 2'd0, 1'b1);
        drain();
        chk("deact_levels", {29'h0, dmactive, ndmreset, haltreq}, 32'h0);
        send(7'h04, 2'd2, 32'h0000_0005, 32'h0, 2'd0, 1'b1);
        send(7'h04, 2'd1, 32'h0, 32'h0, 2'd0, 1'b1);
        send(7'h05, 2'd1, 32'h0, 32'h0, 2'd0, 1'b1);
        send(AbstractCS, 2'd2, 32'h0000_0700, 32'h0, 2'd0, 1'b1);
        send(AbstractCS, 2'd1, 32'h0, 32'h0000_0002, 2'd0, 1'b1);
        send(DMStatus, 2'd1, 32'h0, 32'h0000_0382, 2'd0, 1'b1);
        drain();

        // reset in the middle of a pending response
        resp_ready = 1'b0;
        send(DMControl, 2'd2, 32'h0000_0001, 32'h0, 2'd0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_valid", 32'(resp_valid), 32'd0);
        chk("rst_mid_dmactive", 32'(dmactive), 32'd0);
        resp_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
